// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential signed divider.
package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int STATE_W   = 2;
   localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes: shift in a dividend bit, trial-subtract.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH:0]   divisor,
   output logic [WIDTH:0]   rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH+1:0] rem_sh;
   logic [WIDTH+1:0] trial;

   always_comb begin
      rem_sh = {rem, quo[WIDTH-1]};
      trial  = rem_sh - {1'b0, divisor};
      // A clear sign bit on the trial means the divisor fits into the shifted remainder.
      if (!trial[WIDTH+1]) begin
         rem_next = trial[WIDTH:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = rem_sh[WIDTH:0];
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_seq.sv
// Sequential signed divider (MIPS DIV): quotient to lo_out, remainder to hi_out.
module div_seq
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output div_state_t       state_dbg
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   // Handshake: start is taken only in IDLE; done pulses for exactly one cycle when
   // hi_out/lo_out/div_zero are final, and no new start is taken until IDLE returns.
   div_state_t state, state_d;

   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH:0]   div_q;
   logic             sign_q;
   logic             sign_r;

   logic             load;
   logic             zero_start;
   logic             step_en;
   logic             last_step;

   logic [WIDTH:0]   a_ext, b_ext;
   logic [WIDTH:0]   abs_a, abs_b;
   logic [WIDTH:0]   step_rem;
   logic [WIDTH-1:0] step_quo;

   // Sign-extend by one bit so the most negative operand has a representable magnitude.
   always_comb begin
      a_ext = {a[WIDTH-1], a};
      b_ext = {b[WIDTH-1], b};
      abs_a = a[WIDTH-1] ? -a_ext : a_ext;
      abs_b = b[WIDTH-1] ? -b_ext : b_ext;
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (div_q),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   always_comb begin
      state_d    = state;
      load       = 1'b0;
      zero_start = 1'b0;
      step_en    = 1'b0;
      last_step  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (b == '0) begin
                  zero_start = 1'b1;
                  state_d    = ST_DONE;
               end else begin
                  load    = 1'b1;
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            step_en = 1'b1;
            if (cnt == LAST_CNT) begin
               last_step = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi_out   <= '0;
         lo_out   <= '0;
         cnt      <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         div_q    <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
      end else begin
         busy <= (state_d == ST_RUN);
         done <= (state_d == ST_DONE);
         if (load) begin
            rem_q    <= '0;
            quo_q    <= WIDTH'(abs_a);
            div_q    <= abs_b;
            sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            sign_r   <= a[WIDTH-1];
            cnt      <= '0;
            div_zero <= 1'b0;
         end
         if (zero_start) begin
            div_zero <= 1'b1;
         end
         if (step_en) begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt   <= cnt + 1'b1;
         end
         // Results are taken straight from the final step so they land with the done pulse.
         if (last_step) begin
            lo_out <= sign_q ? -step_quo : step_quo;
            hi_out <= sign_r ? WIDTH'(-step_rem) : WIDTH'(step_rem);
         end
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed MIPS DIV cases plus randomized operands.
module tb_div_seq;
   import div_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, div_zero;
   logic [W-1:0] hi_out, lo_out;
   div_state_t   state_dbg;

   int checks = 0;
   int failures = 0;

   logic [W-1:0] exp_hi = '0;
   logic [W-1:0] exp_lo = '0;
   logic [2*W:0] exp_q[$];

   div_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .hi_out    (hi_out),
      .lo_out    (lo_out),
      .state_dbg (state_dbg)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: plain signed arithmetic, truncating toward zero; b==0 keeps old results.
   function automatic logic [2*W:0] ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [W-1:0] hold_hi, input logic [W-1:0] hold_lo);
      longint sx, sy, q, r;
      logic [63:0] qv, rv;
      if (y == '0) return {1'b1, hold_hi, hold_lo};
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      qv = q;
      rv = r;
      return {1'b0, rv[W-1:0], qv[W-1:0]};
   endfunction

   task automatic run_div(input logic [W-1:0] x, input logic [W-1:0] y, input bit disturb);
      logic [2*W:0] e;
      int lat;
      bit seen;
      e = ref_div(x, y, exp_hi, exp_lo);
      exp_q.push_back(e);
      if (!e[2*W]) begin
         exp_hi = e[2*W-1:W];
         exp_lo = e[W-1:0];
      end
      @(negedge clk);
      a = x;
      b = y;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      check("busy_after_start", W'(busy), W'(y != '0));
      seen = 1'b0;
      while (!seen && lat <= 40) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (disturb && lat == 10) begin
               a = $urandom;
               b = $urandom;
               start = 1'b1;
            end
            if (disturb && lat == 11) start = 1'b0;
            @(negedge clk);
            lat++;
         end
      end
      start = 1'b0;
      e = exp_q.pop_front();
      if (!seen) begin
         check("done_timeout", W'(0), W'(1));
      end else begin
         check("latency", W'(lat), (y == '0) ? W'(1) : W'(W + 1));
         check("lo_out", lo_out, e[W-1:0]);
         check("hi_out", hi_out, e[2*W-1:W]);
         check("div_zero", W'(div_zero), W'(e[2*W]));
         check("busy_at_done", W'(busy), W'(0));
         @(negedge clk);
         check("done_pulse_end", W'(done), W'(0));
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, W'(busy), W'(0));
      check({tag, "_done"}, W'(done), W'(0));
      check({tag, "_dz"}, W'(div_zero), W'(0));
      check({tag, "_hi"}, hi_out, W'(0));
      check({tag, "_lo"}, lo_out, W'(0));
      check({tag, "_state"}, W'(state_dbg), W'(ST_IDLE));
   endtask

   initial begin
      logic [W-1:0] x, y;
      int sel;
      // reset
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      reset = 1'b1;

      // directed cases
      run_div(32'd100, 32'd7, 1'b0);
      run_div(32'hFFFF_FF9C, 32'd7, 1'b0);
      run_div(32'd100, 32'hFFFF_FFF9, 1'b0);
      run_div(32'd9, 32'd4, 1'b0);
      run_div(32'd5, 32'd0, 1'b0);
      run_div(32'd9, 32'd4, 1'b0);
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_div(32'd1000, 32'd3, 1'b1);

      // reset during RUN aborts and clears everything
      @(negedge clk);
      a = 32'd1000;
      b = 32'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("mid_run_busy", W'(busy), W'(1));
      reset = 1'b0;
      #1;
      check_idle_outputs("abort");
      exp_hi = '0;
      exp_lo = '0;
      @(negedge clk);
      reset = 1'b1;
      run_div(32'd20, 32'd6, 1'b0);

      // randomized operands, with zero divisors and the overflow pair mixed in
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         x = $urandom;
         y = $urandom;
         if (sel == 0) y = '0;
         else if (sel == 1) begin
            x = 32'h8000_0000;
            y = 32'hFFFF_FFFF;
         end else if (sel <= 4) begin
            y = W'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1) y = -y;
         end else if (sel == 5) begin
            x = W'($urandom_range(0, 20));
         end
         run_div(x, y, ($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
